mistral_mac_pipe: RTL and testbench

- Parametrised, pipelined multiply-accumulate simulation/mapping model for the Mistral DSP block; the successor to the fixed-size combinational 9x9/18x18/27x27 multiplier boxes.
- Adds configurable operand widths, optional input and pipeline registers, a wrap-around accumulator with add/subtract, a clock enable, and a valid flag that travels with the data.
- Sits between the DSP inference pass and the ALM fabric as the registered DSP primitive.

---
 rtl/mistral_mac_pipe.sv | 117 +++++++++++
 tb/tb_mistral_mac_pipe.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mistral_mac_pipe.sv
// Registered Mistral DSP multiply-accumulate primitive: optional input and product
// registers ahead of a wrap-around accumulator, with a valid flag riding alongside the data.
module mistral_mac_pipe #(
  parameter int unsigned A_WIDTH   = 18,
  parameter int unsigned B_WIDTH   = 18,
  parameter bit          A_SIGNED  = 1'b1,
  parameter bit          B_SIGNED  = 1'b1,
  parameter int unsigned ACC_WIDTH = 64,
  parameter bit          INPUT_REG = 1'b1,
  parameter bit          PIPE_REG  = 1'b1
) (
  input  logic                 CLK,
  input  logic                 ACLR,
  input  logic                 ENA,
  input  logic                 IN_VALID,
  input  logic [A_WIDTH-1:0]   A,
  input  logic [B_WIDTH-1:0]   B,
  input  logic                 ACCUMULATE,
  input  logic                 NEGATE,
  output logic                 OUT_VALID,
  output logic [ACC_WIDTH-1:0] Y
);

  // Stage 0 view of the operands and controls (registered or straight from the ports)
  logic [A_WIDTH-1:0]   s0_a;
  logic [B_WIDTH-1:0]   s0_b;
  logic                 s0_valid;
  logic                 s0_acc;
  logic                 s0_neg;

  // Stage 1 view of the product and its controls
  logic [ACC_WIDTH-1:0] s1_p;
  logic                 s1_valid;
  logic                 s1_acc;
  logic                 s1_neg;

  logic                 a_sign;
  logic                 b_sign;
  logic [ACC_WIDTH-1:0] a_ext;
  logic [ACC_WIDTH-1:0] b_ext;
  logic [ACC_WIDTH-1:0] product;
  logic [ACC_WIDTH-1:0] term;

  generate
    if (INPUT_REG) begin : g_input_reg
      // NOTE: sequential state uses non-blocking assignments so every register samples
      // the pre-edge value of its neighbours, independent of block ordering.
      always_ff @(posedge CLK or negedge ACLR) begin
        if (!ACLR) begin
          s0_a     <= '0;
          s0_b     <= '0;
          s0_valid <= 1'b0;
          s0_acc   <= 1'b0;
          s0_neg   <= 1'b0;
        end else if (ENA) begin
          s0_a     <= A;
          s0_b     <= B;
          s0_valid <= IN_VALID;
          s0_acc   <= ACCUMULATE;
          s0_neg   <= NEGATE;
        end
      end
    end else begin : g_input_bypass
      assign s0_a     = A;
      assign s0_b     = B;
      assign s0_valid = IN_VALID;
      assign s0_acc   = ACCUMULATE;
      assign s0_neg   = NEGATE;
    end
  endgenerate

  // Widening to the accumulator width makes the truncated product exact modulo 2^ACC_WIDTH.
  assign a_sign  = A_SIGNED ? s0_a[A_WIDTH-1] : 1'b0;
  assign b_sign  = B_SIGNED ? s0_b[B_WIDTH-1] : 1'b0;
  assign a_ext   = {{(ACC_WIDTH - A_WIDTH){a_sign}}, s0_a};
  assign b_ext   = {{(ACC_WIDTH - B_WIDTH){b_sign}}, s0_b};
  assign product = a_ext * b_ext;

  generate
    if (PIPE_REG) begin : g_pipe_reg
      always_ff @(posedge CLK or negedge ACLR) begin
        if (!ACLR) begin
          s1_p     <= '0;
          s1_valid <= 1'b0;
          s1_acc   <= 1'b0;
          s1_neg   <= 1'b0;
        end else if (ENA) begin
          s1_p     <= product;
          s1_valid <= s0_valid;
          s1_acc   <= s0_acc;
          s1_neg   <= s0_neg;
        end
      end
    end else begin : g_pipe_bypass
      assign s1_p     = product;
      assign s1_valid = s0_valid;
      assign s1_acc   = s0_acc;
      assign s1_neg   = s0_neg;
    end
  endgenerate

  assign term = s1_neg ? (~s1_p + 1'b1) : s1_p;

  // Invalid slots only clear the output flag; the accumulator keeps its value.
  always_ff @(posedge CLK or negedge ACLR) begin
    if (!ACLR) begin
      Y         <= '0;
      OUT_VALID <= 1'b0;
    end else if (ENA) begin
      OUT_VALID <= s1_valid;
      if (s1_valid) begin
        Y <= s1_acc ? (Y + term) : term;
      end
    end
  end

endmodule

// File: tb/tb_mistral_mac_pipe.sv
// Bench for mistral_mac_pipe: five configurations share one stimulus stream and are each
// compared every cycle against an ordered-operation model with a per-configuration delay.
module tb_mistral_mac_pipe;

  localparam int NDUT = 5;
  localparam int AW   [NDUT] = '{18, 27, 27, 18, 8};
  localparam int BW   [NDUT] = '{18, 27, 27, 18, 6};
  localparam bit AS   [NDUT] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  localparam bit BS   [NDUT] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  localparam int ACCW [NDUT] = '{64, 64, 64, 36, 14};
  localparam int LAT  [NDUT] = '{3, 1, 1, 2, 2};

  typedef struct {
    bit          v;
    bit          acc;
    logic [63:0] term;
  } samp_t;

  logic        clk;
  logic        aclr;
  logic        ena;
  logic        in_valid;
  logic [26:0] a_drv;
  logic [26:0] b_drv;
  logic        accumulate;
  logic        negate;

  logic        ov0, ov1, ov2, ov3, ov4;
  logic [63:0] y0, y1, y2;
  logic [35:0] y3;
  logic [13:0] y4;

  int n_tests = 0;
  int n_fail  = 0;

  samp_t       pend [NDUT][$];
  logic [63:0] m_acc [NDUT];
  bit          m_v   [NDUT];

  mistral_mac_pipe #(.A_WIDTH(18), .B_WIDTH(18), .A_SIGNED(1'b1), .B_SIGNED(1'b1),
                     .ACC_WIDTH(64), .INPUT_REG(1'b1), .PIPE_REG(1'b1)) dut0 (
    .CLK(clk), .ACLR(aclr), .ENA(ena), .IN_VALID(in_valid), .A(a_drv[17:0]), .B(b_drv[17:0]),
    .ACCUMULATE(accumulate), .NEGATE(negate), .OUT_VALID(ov0), .Y(y0));

  mistral_mac_pipe #(.A_WIDTH(27), .B_WIDTH(27), .A_SIGNED(1'b0), .B_SIGNED(1'b0),
                     .ACC_WIDTH(64), .INPUT_REG(1'b0), .PIPE_REG(1'b0)) dut1 (
    .CLK(clk), .ACLR(aclr), .ENA(ena), .IN_VALID(in_valid), .A(a_drv), .B(b_drv),
    .ACCUMULATE(accumulate), .NEGATE(negate), .OUT_VALID(ov1), .Y(y1));

  mistral_mac_pipe #(.A_WIDTH(27), .B_WIDTH(27), .A_SIGNED(1'b1), .B_SIGNED(1'b1),
                     .ACC_WIDTH(64), .INPUT_REG(1'b0), .PIPE_REG(1'b0)) dut2 (
    .CLK(clk), .ACLR(aclr), .ENA(ena), .IN_VALID(in_valid), .A(a_drv), .B(b_drv),
    .ACCUMULATE(accumulate), .NEGATE(negate), .OUT_VALID(ov2), .Y(y2));

  mistral_mac_pipe #(.A_WIDTH(18), .B_WIDTH(18), .A_SIGNED(1'b1), .B_SIGNED(1'b1),
                     .ACC_WIDTH(36), .INPUT_REG(1'b1), .PIPE_REG(1'b0)) dut3 (
    .CLK(clk), .ACLR(aclr), .ENA(ena), .IN_VALID(in_valid), .A(a_drv[17:0]), .B(b_drv[17:0]),
    .ACCUMULATE(accumulate), .NEGATE(negate), .OUT_VALID(ov3), .Y(y3));

  mistral_mac_pipe #(.A_WIDTH(8), .B_WIDTH(6), .A_SIGNED(1'b1), .B_SIGNED(1'b0),
                     .ACC_WIDTH(14), .INPUT_REG(1'b0), .PIPE_REG(1'b1)) dut4 (
    .CLK(clk), .ACLR(aclr), .ENA(ena), .IN_VALID(in_valid), .A(a_drv[7:0]), .B(b_drv[5:0]),
    .ACCUMULATE(accumulate), .NEGATE(negate), .OUT_VALID(ov4), .Y(y4));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [63:0] width_mask(int w);
    if (w >= 64) return '1;
    return (64'd1 << w) - 64'd1;
  endfunction

  // Signed integer value of the low w bits of x under the given signedness.
  function automatic logic signed [127:0] as_int(logic [26:0] x, int w, bit sgn);
    logic signed [127:0] r;
    r = '0;
    for (int i = 0; i < w; i++) r[i] = x[i];
    if (sgn && x[w-1]) r = r - (128'sd1 <<< w);
    return r;
  endfunction

  function automatic logic [63:0] term_of(int d, logic [26:0] a, logic [26:0] b, bit neg);
    logic signed [127:0] p;
    p = as_int(a, AW[d], AS[d]) * as_int(b, BW[d], BS[d]);
    if (neg) p = -p;
    return p[63:0] & width_mask(ACCW[d]);
  endfunction

  function automatic logic [63:0] obs_y(int d);
    case (d)
      0:       return y0;
      1:       return y1;
      2:       return y2;
      3:       return {28'd0, y3};
      default: return {50'd0, y4};
    endcase
  endfunction

  function automatic logic obs_v(int d);
    case (d)
      0:       return ov0;
      1:       return ov1;
      2:       return ov2;
      3:       return ov3;
      default: return ov4;
    endcase
  endfunction

  task automatic model_reset();
    for (int d = 0; d < NDUT; d++) begin
      pend[d].delete();
      m_acc[d] = '0;
      m_v[d]   = 1'b0;
    end
  endtask

  // Each enabled edge records one operation; an operation's effect becomes visible
  // LAT-1 enabled edges after the edge that sampled it.
  task automatic model_edge();
    samp_t s;
    for (int d = 0; d < NDUT; d++) begin
      s.v    = in_valid;
      s.acc  = accumulate;
      s.term = term_of(d, a_drv, b_drv, negate);
      pend[d].push_back(s);
      if (pend[d].size() >= LAT[d]) begin
        s = pend[d].pop_front();
        m_v[d] = s.v;
        if (s.v) m_acc[d] = s.acc ? ((m_acc[d] + s.term) & width_mask(ACCW[d])) : s.term;
      end
    end
  endtask

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_tests++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic check_all(input string ph);
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("%s dut%0d OUT_VALID", ph, d), {63'd0, obs_v(d)}, {63'd0, m_v[d]});
      check($sformatf("%s dut%0d Y", ph, d), obs_y(d), m_acc[d]);
    end
  endtask

  task automatic step(input bit v, input logic [26:0] a, input logic [26:0] b,
                      input bit acc, input bit neg, input bit en, input string ph);
    in_valid   = v;
    a_drv      = a;
    b_drv      = b;
    accumulate = acc;
    negate     = neg;
    ena        = en;
    @(posedge clk);
    if (en && aclr) model_edge();
    #1;
    check_all(ph);
  endtask

  initial begin
    aclr = 1'b1; ena = 1'b1; in_valid = 1'b0;
    a_drv = '0; b_drv = '0; accumulate = 1'b0; negate = 1'b0;
    model_reset();
    #2 aclr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("reset dut%0d Y", d), obs_y(d), 64'd0);
      check($sformatf("reset dut%0d OUT_VALID", d), {63'd0, obs_v(d)}, 64'd0);
    end
    @(negedge clk);
    aclr = 1'b1;

    // Single signed multiply on the default configuration: -3 * 5
    step(1, 27'(-3), 27'd5, 0, 0, 1, "t1");
    step(0, 27'd0, 27'd0, 0, 0, 1, "t1");
    step(0, 27'd0, 27'd0, 0, 0, 1, "t1");
    check("t1 y0", y0, 64'hFFFF_FFFF_FFFF_FFF1);
    check("t1 ov0", {63'd0, ov0}, 64'd1);
    step(0, 27'd0, 27'd0, 0, 0, 1, "t1");
    check("t1 ov0 pulse end", {63'd0, ov0}, 64'd0);
    step(0, 27'd0, 27'd0, 0, 0, 1, "t1");

    // Accumulate stream: 6, 26, 25
    step(1, 27'd2, 27'd3, 0, 0, 1, "t2");
    step(1, 27'd4, 27'd5, 1, 0, 1, "t2");
    step(1, 27'd1, 27'd1, 1, 1, 1, "t2");
    check("t2 y0 first", y0, 64'd6);
    step(0, 27'd0, 27'd0, 0, 0, 1, "t2");
    check("t2 y0 second", y0, 64'd26);
    step(0, 27'd0, 27'd0, 0, 0, 1, "t2");
    check("t2 y0 third", y0, 64'd25);
    check("t2 ov0 third", {63'd0, ov0}, 64'd1);
    step(0, 27'd0, 27'd0, 0, 0, 1, "t2");
    step(0, 27'd0, 27'd0, 0, 0, 1, "t2");

    // 27x27 corner, unsigned and signed, both registers bypassed
    step(1, 27'h7FF_FFFF, 27'h7FF_FFFF, 0, 0, 1, "t3");
    check("t3 unsigned y1", y1, 64'h003F_FFFF_F000_0001);
    check("t3 signed y2", y2, 64'd1);
    step(0, 27'd0, 27'd0, 0, 0, 1, "t3");
    step(0, 27'd0, 27'd0, 0, 0, 1, "t3");

    // Stall for four disabled edges inside the accumulate stream; junk inputs are ignored
    step(1, 27'd2, 27'd3, 0, 0, 1, "t4");
    for (int i = 0; i < 4; i++) step(1, 27'd9, 27'd9, 1, 1, 0, "t4 stall");
    step(1, 27'd4, 27'd5, 1, 0, 1, "t4");
    step(1, 27'd1, 27'd1, 1, 1, 1, "t4");
    check("t4 y0 first", y0, 64'd6);
    step(0, 27'd0, 27'd0, 0, 0, 1, "t4");
    check("t4 y0 second", y0, 64'd26);
    step(0, 27'd0, 27'd0, 0, 0, 1, "t4");
    check("t4 y0 third", y0, 64'd25);
    step(0, 27'd0, 27'd0, 0, 0, 1, "t4");
    check("t4 no duplicate pulse", {63'd0, ov0}, 64'd0);
    step(0, 27'd0, 27'd0, 0, 0, 1, "t4");

    // 36-bit wrap and an invalid slot carrying ACCUMULATE=1
    step(1, 27'(-1), 27'd1, 0, 0, 1, "t5");
    step(1, 27'd1, 27'd1, 1, 0, 1, "t5");
    check("t5 y3 all ones", {28'd0, y3}, 64'hF_FFFF_FFFF);
    step(0, 27'd7, 27'd7, 1, 0, 1, "t5");
    check("t5 y3 wrapped", {28'd0, y3}, 64'd0);
    step(1, 27'd2, 27'd3, 1, 0, 1, "t5");
    check("t5 y3 gap hold", {28'd0, y3}, 64'd0);
    check("t5 ov3 gap", {63'd0, ov3}, 64'd0);
    step(0, 27'd0, 27'd0, 0, 0, 1, "t5");
    check("t5 y3 after gap", {28'd0, y3}, 64'd6);
    step(0, 27'd0, 27'd0, 0, 0, 1, "t5");

    // Random operations with random stalls and gaps
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 4) != 0, 27'($urandom), 27'($urandom), 1'($urandom % 2),
           ($urandom % 4) == 0, ($urandom % 5) != 0, $sformatf("rnd%0d", i));
    end

    // Asynchronous reset with data in flight
    step(1, 27'd5, 27'd6, 1, 0, 1, "t6");
    #3 aclr = 1'b0;
    #1;
    model_reset();
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("t6 async dut%0d Y", d), obs_y(d), 64'd0);
      check($sformatf("t6 async dut%0d OUT_VALID", d), {63'd0, obs_v(d)}, 64'd0);
    end
    #2 aclr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(0, 27'd3, 27'd3, 1, 0, 1, "t6 release");
      for (int d = 0; d < NDUT; d++)
        check($sformatf("t6 no stale dut%0d", d), {63'd0, obs_v(d)}, 64'd0);
    end
    step(1, 27'd3, 27'd4, 1, 0, 1, "t6 resume");
    for (int i = 0; i < 3; i++) step(0, 27'd0, 27'd0, 0, 0, 1, "t6 resume");
    check("t6 y0 after resume", y0, 64'd12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
